// File: rtl/TYPES.sv
// ---------------------------------------------------------------------------
// TYPES -- shared definitions for the instruction-memory loader.
//
// Holds the target memory geometry and the loader state encoding so the
// loader and anything that reads the same memory agree on one definition.
//   MEM_DEPTH      byte locations in the target memory
//   MEM_WIDTH      bits per memory location
//   BPI            bytes per 32-bit instruction word
//   ADDR_W         byte-address width
//   WCNT_W         word-count width (holds 0..MEM_DEPTH/BPI)
//   loader_state_t loader FSM state encoding
// ---------------------------------------------------------------------------
package TYPES;

    localparam int MEM_DEPTH = 4096;
    localparam int MEM_WIDTH = 8;
    localparam int BPI       = 4;
    localparam int ADDR_W    = 12;
    localparam int WCNT_W    = 11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERROR  = 3'd4
    } loader_state_t;

endpackage : TYPES

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader -- streams 32-bit words into a byte-wide instruction memory.
//
// A session is requested with a one-cycle load_start carrying a byte base
// address and a word count. Each accepted word is written as four bytes,
// most significant byte first, on four consecutive cycles. The memory is
// external; this block only drives its write port.
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE   | waiting for load_start; range-checks the request
// ACCEPT | in_ready high, waiting for an in_valid handshake
// WRITE  | four byte writes of the latched word, big-endian
// FINISH | one-cycle done pulse, then IDLE
// ERROR  | request rejected; err is set, back to IDLE next cycle
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset, released synchronously
//   load_start   one-cycle session request (honoured in IDLE only)
//   load_base    first byte address of the session
//   load_words   words in the session (0..MEM_DEPTH/BPI)
//   in_valid     in_data holds a word
//   in_data      word to store
//   in_ready     word accepted when in_valid & in_ready
//   mem_we       byte write strobe
//   mem_addr     byte write address (0 when mem_we is low)
//   mem_wdata    byte write data    (0 when mem_we is low)
//   busy         session in progress (ACCEPT or WRITE)
//   done         one-cycle completion pulse
//   err          sticky rejected-session flag
//   words_loaded words fully written in the current or last session
// ---------------------------------------------------------------------------
module imem_loader
    import TYPES::*;
#(
    parameter int MEM_DEPTH = TYPES::MEM_DEPTH,
    parameter int BPI       = TYPES::BPI
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic [ADDR_W-1:0]    load_base,
    input  logic [WCNT_W-1:0]    load_words,
    input  logic                 in_valid,
    input  logic [31:0]          in_data,
    output logic                 in_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [MEM_WIDTH-1:0] mem_wdata,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [WCNT_W-1:0]    words_loaded
);

    // One bit wider than the 13 bits needed for legal requests so that an
    // oversized word count cannot wrap the end address back into range.
    localparam int LIMIT_W = ADDR_W + 2;

    loader_state_t        r_state;
    logic                 r_rst_ok;
    logic [ADDR_W-1:0]    r_addr;
    logic [WCNT_W-1:0]    r_count;
    logic [31:0]          r_shift;
    logic [1:0]           r_idx;

    logic                 r_in_ready;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [MEM_WIDTH-1:0] r_mem_wdata;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic [WCNT_W-1:0]    r_words;

    logic [LIMIT_W-1:0]   w_end;
    logic                 w_bad_req;
    logic                 w_last_word;

    // Reset is asserted asynchronously but released on a clock edge: the
    // FSM ignores load_start until one edge after rst_n rises, so the first
    // request can be honoured on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_ok <= 1'b0;
        end else begin
            r_rst_ok <= 1'b1;
        end
    end

    assign w_end       = {2'b00, load_base}
                       + ({3'b000, load_words} * LIMIT_W'(BPI));
    assign w_bad_req   = (load_base[1:0] != 2'b00)
                       || (w_end > LIMIT_W'(MEM_DEPTH));
    assign w_last_word = ((r_words + 1'b1) == r_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_shift     <= '0;
            r_idx       <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_words     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (load_start && r_rst_ok) begin
                        if (w_bad_req) begin
                            r_err   <= 1'b1;
                            r_state <= ST_ERROR;
                        end else if (load_words == '0) begin
                            r_words <= '0;
                            r_err   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_addr     <= load_base;
                            r_count    <= load_words;
                            r_words    <= '0;
                            r_err      <= 1'b0;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= ST_ACCEPT;
                        end
                    end
                end

                ST_ACCEPT: begin
                    if (in_valid && r_in_ready) begin
                        // Top byte goes out straight away; the rest are
                        // shifted up so the next byte is always [31:24].
                        r_shift     <= {in_data[23:0], 8'h00};
                        r_idx       <= 2'd0;
                        r_in_ready  <= 1'b0;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_addr;
                        r_mem_wdata <= in_data[31:24];
                        r_state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (r_idx != 2'd3) begin
                        r_idx       <= r_idx + 2'd1;
                        r_mem_addr  <= r_mem_addr + 1'b1;
                        r_mem_wdata <= r_shift[31:24];
                        r_shift     <= {r_shift[23:0], 8'h00};
                    end else begin
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_words     <= r_words + 1'b1;
                        // After the final word of a session ending at the
                        // top of memory this wraps, but it is never used.
                        r_addr      <= r_addr + ADDR_W'(BPI);
                        if (w_last_word) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FINISH;
                        end else begin
                            r_in_ready <= 1'b1;
                            r_state    <= ST_ACCEPT;
                        end
                    end
                end

                ST_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_ERROR: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_in_ready  <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_wdata    = r_mem_wdata;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err          = r_err;
    assign words_loaded = r_words;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader -- directed self-checking bench for imem_loader.
// ---------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [11:0] load_base;
    logic [10:0] load_words;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [10:0] words_loaded;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_start   (load_start),
        .load_base    (load_base),
        .load_words   (load_words),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // write log, handshake and done capture
    int          cyc = 0;
    int          nwr = 0;
    logic [11:0] wa [0:63];
    logic [7:0]  wd [0:63];
    int          wc [0:63];
    int          nhs = 0;
    int          hs_cyc [0:7];
    int          ndone = 0;
    int          done_cyc = 0;
    int          ls_cyc = 0;
    int          idle_bad = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (in_valid && in_ready && rst_n) begin
            if (nhs < 8) hs_cyc[nhs] = cyc;
            nhs = nhs + 1;
        end
        if (load_start) ls_cyc = cyc;
    end

    always @(negedge clk) begin
        if (mem_we) begin
            if (nwr < 64) begin
                wa[nwr] = mem_addr;
                wd[nwr] = mem_wdata;
                wc[nwr] = cyc;
            end
            nwr = nwr + 1;
        end else if (mem_addr != 12'h000 || mem_wdata != 8'h00) begin
            idle_bad = idle_bad + 1;
        end
        if (done) begin
            ndone    = ndone + 1;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log;
        nwr   = 0;
        nhs   = 0;
        ndone = 0;
    endtask

    task automatic start(input logic [11:0] b, input logic [10:0] w);
        load_start = 1'b1;
        load_base  = b;
        load_words = w;
        step;
        load_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            step;
            n++;
        end
        step;
        in_valid = 1'b0;
        if (n >= 50) chk("hs_timeout", n, 0);
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (ndone == 0 && n < 60) begin
            step;
            n++;
        end
        chk(tag, (ndone != 0), 1'b1);
        repeat (3) step;
    endtask

    // expected byte i of a big-endian word stream
    function automatic logic [7:0] exp_byte(input logic [31:0] w, input int i);
        logic [31:0] s;
        s = w >> (24 - 8 * (i % 4));
        return s[7:0];
    endfunction

    logic [31:0] words3 [0:2];
    logic [31:0] words4 [0:3];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        words3 = '{32'h01020304, 32'hA5B6C7D8, 32'hF00D1234};
        words4 = '{32'h10203040, 32'h50607080, 32'h90A0B0C0, 32'hD0E0F0FF};

        rst_n      = 1'b0;
        load_start = 1'b0;
        load_base  = '0;
        load_words = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        repeat (3) step;

        // reset state
        chk("rst_ctl",   {in_ready, mem_we, busy, done, err}, 5'b0);
        chk("rst_addr",  mem_addr, 12'h000);
        chk("rst_data",  mem_wdata, 8'h00);
        chk("rst_words", words_loaded, 11'd0);

        // release: request on first edge is ignored, second edge honoured
        rst_n = 1'b1;
        load_start = 1'b1;
        load_base  = 12'h100;
        load_words = 11'd1;
        step;
        chk("rel_edge1_busy", busy, 1'b0);
        load_base = 12'h010;
        step;
        load_start = 1'b0;
        chk("rel_edge2_busy", busy, 1'b1);
        chk("rel_edge2_rdy",  in_ready, 1'b1);

        // single-word session
        send_word(32'h8C220004);
        wait_done("s1_done_to");
        chk("s1_nwr", nwr, 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("s1_a%0d", i), wa[i], 12'h010 + 12'(i));
            chk($sformatf("s1_c%0d", i), wc[i], hs_cyc[0] + i);
        end
        chk("s1_d0", wd[0], 8'h8C);
        chk("s1_d1", wd[1], 8'h22);
        chk("s1_d2", wd[2], 8'h00);
        chk("s1_d3", wd[3], 8'h04);
        chk("s1_done_cyc", done_cyc, wc[3] + 1);
        chk("s1_ndone", ndone, 1);
        chk("s1_words", words_loaded, 11'd1);
        chk("s1_busy", busy, 1'b0);

        // backpressure: 7 idle cycles in ACCEPT before word 2
        clear_log;
        start(12'h100, 11'd3);
        send_word(words3[0]);
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        bad = 0;
        repeat (7) begin
            if (!in_ready || mem_we) bad++;
            step;
        end
        chk("bp_stall", bad, 0);
        chk("bp_nwr_mid", nwr, 4);
        send_word(words3[1]);
        send_word(words3[2]);
        wait_done("bp_done_to");
        chk("bp_nwr", nwr, 12);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("bp_a%0d", i), wa[i], 12'h100 + 12'(i));
            chk($sformatf("bp_d%0d", i), wd[i], exp_byte(words3[i / 4], i));
        end
        chk("bp_rate", hs_cyc[2] - hs_cyc[1], 5);
        chk("bp_words", words_loaded, 11'd3);
        chk("bp_ndone", ndone, 1);

        // misaligned base rejected
        clear_log;
        start(12'h002, 11'd1);
        repeat (2) step;
        chk("mis_err", err, 1'b1);
        chk("mis_busy", busy, 1'b0);
        chk("mis_nwr", nwr, 0);
        chk("mis_ndone", ndone, 0);

        // last word at top of memory is legal and clears err
        clear_log;
        start(12'hFFC, 11'd1);
        chk("top_err_clr", err, 1'b0);
        send_word(32'hA1B2C3D4);
        wait_done("top_done_to");
        chk("top_nwr", nwr, 4);
        chk("top_a3", wa[3], 12'hFFF);
        chk("top_d3", wd[3], 8'hD4);

        // one word past the end rejected
        clear_log;
        start(12'hFF0, 11'd5);
        repeat (2) step;
        chk("ovf_err", err, 1'b1);
        chk("ovf_nwr", nwr, 0);

        // exactly reaching the end is legal
        clear_log;
        start(12'hFF0, 11'd4);
        for (int i = 0; i < 4; i++) send_word(words4[i]);
        wait_done("fit_done_to");
        chk("fit_nwr", nwr, 16);
        chk("fit_a15", wa[15], 12'hFFF);
        chk("fit_d15", wd[15], 8'hFF);
        chk("fit_d4", wd[4], 8'h50);
        chk("fit_err", err, 1'b0);
        chk("fit_words", words_loaded, 11'd4);

        // zero-length session
        clear_log;
        start(12'h040, 11'd0);
        chk("zero_done_cyc", done_cyc, ls_cyc);
        repeat (3) step;
        chk("zero_ndone", ndone, 1);
        chk("zero_nwr", nwr, 0);
        chk("zero_words", words_loaded, 11'd0);

        // reset during the second byte of word 1
        clear_log;
        start(12'h200, 11'd2);
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        step;
        in_valid = 1'b0;
        step;
        chk("rm_nwr_pre", nwr, 2);
        rst_n = 1'b0;
        #1;
        chk("rm_we", mem_we, 1'b0);
        chk("rm_addr", mem_addr, 12'h000);
        chk("rm_data", mem_wdata, 8'h00);
        chk("rm_busy", busy, 1'b0);
        repeat (2) step;
        rst_n = 1'b1;
        repeat (10) step;
        chk("rm_nwr_post", nwr, 2);
        clear_log;
        start(12'h300, 11'd1);
        send_word(32'h11223344);
        wait_done("rm_new_done_to");
        chk("rm_new_nwr", nwr, 4);
        chk("rm_new_a0", wa[0], 12'h300);
        chk("rm_new_d0", wd[0], 8'h11);
        chk("rm_new_d3", wd[3], 8'h44);

        // load_start during WRITE is ignored
        clear_log;
        start(12'h400, 11'd2);
        send_word(32'hCAFEF00D);
        start(12'h800, 11'd1);
        send_word(32'h0BADC0DE);
        wait_done("ign_done_to");
        chk("ign_nwr", nwr, 8);
        chk("ign_a7", wa[7], 12'h407);
        chk("ign_d0", wd[0], 8'hCA);
        chk("ign_d7", wd[7], 8'hDE);
        chk("ign_words", words_loaded, 11'd2);
        chk("ign_ndone", ndone, 1);

        chk("idle_zero", idle_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_imem_loader
